// File: rtl/data_mem_timer.sv
// rtl/data_mem_timer.sv - data-memory-port timer: prescaled 32-bit counter, compare match, irq (option: TIMER_ONESHOT_EN)
module data_mem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataMemRAddr,
    input  logic [31:0] dataMemWData,
    input  logic        dataMem_wr_en,
    output logic [31:0] dataMemRData,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] SEL_CTRL   = 3'd0;
    localparam logic [2:0] SEL_PSC    = 3'd1;
    localparam logic [2:0] SEL_CNT    = 3'd2;
    localparam logic [2:0] SEL_CMP    = 3'd3;
    localparam logic [2:0] SEL_STATUS = 3'd4;

    logic        ctrl_en;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic        ctrl_oneshot;
    logic [15:0] psc;
    logic [15:0] psc_cnt;
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic        match;

    logic [2:0]  sel;
    logic        wr;
    logic        tick;
    logic        match_evt;

    // Byte lanes are not decoded: every access is a full word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dataMemRAddr[1:0];

    assign hit       = (dataMemRAddr[31:5] == BASE_ADDR[31:5]);
    assign sel       = dataMemRAddr[4:2];
    assign wr        = dataMem_wr_en & hit;
    assign tick      = ctrl_en & (psc_cnt == psc);
    // Compare against the pre-update CNT and CMP so a same-cycle CMP write does not affect this match.
    assign match_evt = tick & (cnt == cmp);
    assign irq       = match & ctrl_irq_en;

`ifdef TIMER_ONESHOT_EN
    // One-shot control bit; EN self-clears on a match unless software rewrites CTRL that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_oneshot <= 1'b0;
        end else if (wr && sel == SEL_CTRL) begin
            ctrl_oneshot <= dataMemWData[3];
        end
    end
`else
    assign ctrl_oneshot = 1'b0;
`endif

    // CTRL register; software write takes priority over the hardware EN clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
        end else if (wr && sel == SEL_CTRL) begin
            ctrl_en          <= dataMemWData[0];
            ctrl_auto_reload <= dataMemWData[1];
            ctrl_irq_en      <= dataMemWData[2];
        end else if (match_evt && ctrl_oneshot) begin
            ctrl_en          <= 1'b0;
        end
    end

    // Prescaler value and divider; a PSC write restarts the divider.
    always_ff @(posedge clk) begin
        if (!reset) begin
            psc     <= 16'd0;
            psc_cnt <= 16'd0;
        end else if (wr && sel == SEL_PSC) begin
            psc     <= dataMemWData[15:0];
            psc_cnt <= 16'd0;
        end else if (ctrl_en) begin
            psc_cnt <= tick ? 16'd0 : psc_cnt + 16'd1;
        end
    end

    // Main counter; software write overrides the tick update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 32'd0;
        end else if (wr && sel == SEL_CNT) begin
            cnt <= dataMemWData;
        end else if (tick) begin
            cnt <= (match_evt && ctrl_auto_reload) ? 32'd0 : cnt + 32'd1;
        end
    end

    // Compare register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp <= 32'd0;
        end else if (wr && sel == SEL_CMP) begin
            cmp <= dataMemWData;
        end
    end

    // Sticky MATCH flag; a new match beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match <= 1'b0;
        end else if (match_evt) begin
            match <= 1'b1;
        end else if (wr && sel == SEL_STATUS && dataMemWData[0]) begin
            match <= 1'b0;
        end
    end

    // Zero-latency read mux so the single-cycle core sees data in the access cycle.
    always_comb begin
        dataMemRData = 32'd0;
        if (hit) begin
            case (sel)
                SEL_CTRL:   dataMemRData = {28'd0, ctrl_oneshot, ctrl_irq_en, ctrl_auto_reload, ctrl_en};
                SEL_PSC:    dataMemRData = {16'd0, psc};
                SEL_CNT:    dataMemRData = cnt;
                SEL_CMP:    dataMemRData = cmp;
                SEL_STATUS: dataMemRData = {31'd0, match};
                default:    dataMemRData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_timer.sv
// tb/tb_data_mem_timer.sv - randomized and directed check of data_mem_timer against a behavioural model
module tb_data_mem_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef TIMER_ONESHOT_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural view of the register file.
    logic [3:0]  m_ctrl;
    logic [15:0] m_psc;
    int          m_div;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_match;

    always #5 clk = ~clk;

    data_mem_timer #(.BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .dataMemRAddr (addr),
        .dataMemWData (wdata),
        .dataMem_wr_en(we),
        .dataMemRData (rdata),
        .hit          (hit),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'd0;
        case (a[4:2])
            3'd0:    return {28'd0, m_ctrl};
            3'd1:    return {16'd0, m_psc};
            3'd2:    return m_cnt;
            3'd3:    return m_cmp;
            3'd4:    return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the current bus inputs.
    task automatic model_edge();
        logic w;
        logic tk;
        logic ev;
        logic [3:0]  n_ctrl;
        logic [15:0] n_psc;
        int          n_div;
        logic [31:0] n_cnt;
        logic [31:0] n_cmp;
        logic        n_match;
        if (!reset) begin
            m_ctrl = 0; m_psc = 0; m_div = 0; m_cnt = 0; m_cmp = 0; m_match = 0;
            return;
        end
        w  = we && m_hit(addr);
        tk = m_ctrl[0] && (m_div == int'(m_psc));
        ev = tk && (m_cnt == m_cmp);
        n_ctrl = m_ctrl; n_psc = m_psc; n_div = m_div;
        n_cnt = m_cnt; n_cmp = m_cmp; n_match = m_match;
        if (m_ctrl[0]) n_div = tk ? 0 : m_div + 1;
        if (tk) n_cnt = (ev && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
        if (ev) n_match = 1'b1;
`ifdef TIMER_ONESHOT_EN
        if (ev && m_ctrl[3]) n_ctrl[0] = 1'b0;
`endif
        if (w) begin
            case (addr[4:2])
                3'd0: n_ctrl = wdata[3:0] & CTRL_MASK;
                3'd1: begin n_psc = wdata[15:0]; n_div = 0; end
                3'd2: n_cnt = wdata;
                3'd3: n_cmp = wdata;
                3'd4: if (wdata[0] && !ev) n_match = 1'b0;
                default: ;
            endcase
        end
        m_ctrl = n_ctrl; m_psc = n_psc; m_div = n_div;
        m_cnt = n_cnt; m_cmp = n_cmp; m_match = n_match;
    endtask

    // One bus cycle: drive, sample at the falling edge, then step model on the rising edge.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic rst, input bit chk, output logic [31:0] obs);
        addr = a; wdata = d; we = w; reset = rst;
        @(negedge clk);
        obs = rdata;
        if (chk) begin
            check("rdata", rdata, m_read(a));
            check("hit", {31'd0, hit}, {31'd0, m_hit(a)});
            check("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        logic [31:0] obs;
        cycle(BASE + 32'(off * 4), d, 1'b1, 1'b1, 1'b1, obs);
    endtask

    task automatic rd_n(input int off, input int n);
        logic [31:0] obs;
        for (int i = 0; i < n; i++) cycle(BASE + 32'(off * 4), 32'd0, 1'b0, 1'b1, 1'b1, obs);
    endtask

    task automatic rd_expect(input string tag, input int off, input logic [31:0] v);
        logic [31:0] obs;
        cycle(BASE + 32'(off * 4), 32'd0, 1'b0, 1'b1, 1'b1, obs);
        check(tag, obs, v);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        r;
        m_ctrl = 0; m_psc = 0; m_div = 0; m_cnt = 0; m_cmp = 0; m_match = 0;

        // Reset and decode
        cycle(BASE, 32'd0, 1'b0, 1'b0, 1'b0, obs);
        cycle(BASE, 32'd0, 1'b0, 1'b0, 1'b0, obs);
        for (int i = 0; i < 8; i++) rd_expect("reset_reg", i, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        cycle(BASE + 32'h20, 32'd0, 1'b0, 1'b1, 1'b1, obs);
        check("miss_data", obs, 32'd0);

        // Prescaled count, then hold with EN cleared
        wr(1, 32'd3); wr(2, 32'd0); wr(0, 32'd1);
        rd_n(2, 12);
        rd_expect("psc_count", 2, 32'd3);
        wr(0, 32'd0);
        rd_n(2, 10);
        rd_expect("psc_hold", 2, 32'd3);

        // Auto-reload match with irq, then W1C
        wr(1, 32'd0); wr(2, 32'd0); wr(3, 32'd5); wr(0, 32'd7);
        rd_n(2, 10);
        wr(0, 32'd0);
        rd_expect("match_sticky", 4, 32'd1);
        wr(4, 32'd1);
        rd_expect("match_cleared", 4, 32'd0);

        // Wrap without a flag
        wr(3, 32'h10); wr(1, 32'd0); wr(2, 32'hFFFF_FFFF); wr(0, 32'd1);
        rd_expect("pre_wrap", 2, 32'hFFFF_FFFF);
        rd_expect("wrap", 2, 32'd0);
        rd_expect("wrap_nomatch", 4, 32'd0);

        // Software write to CNT beats the tick; match-set beats W1C
        wr(2, 32'h40);
        rd_expect("cnt_write_wins", 2, 32'h40);
        wr(3, 32'h42);
        wr(4, 32'd1);
        rd_expect("match_set_wins", 4, 32'd1);

        // Reset in the middle of counting, with a concurrent CNT write
        wr(2, 32'h20);
        cycle(BASE + 32'h8, 32'h55, 1'b1, 1'b0, 1'b1, obs);
        for (int i = 0; i < 5; i++) rd_expect("midreset_reg", i, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);

        // One-shot behaviour (or its absence)
        wr(1, 32'd0); wr(2, 32'd0); wr(3, 32'd2); wr(0, 32'hB);
        rd_n(2, 6);
`ifdef TIMER_ONESHOT_EN
        rd_expect("oneshot_ctrl", 0, 32'hA);
        rd_expect("oneshot_cnt", 2, 32'd0);
`else
        rd_expect("no_oneshot_ctrl", 0, 32'h3);
`endif
        wr(0, 32'd0);

        // Randomized traffic checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = BASE + 32'($urandom_range(0, 31));
            w = ($urandom_range(0, 3) == 0);
            case (a[4:2])
                3'd0:    d = 32'($urandom_range(0, 15)) | ($urandom() & 32'hFFFF_FFF0);
                3'd1:    d = 32'($urandom_range(0, 3));
                3'd2:    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 20));
                3'd3:    d = 32'($urandom_range(0, 20));
                default: d = $urandom();
            endcase
            cycle(a, d, w, r, 1'b1, obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_timer.md
# data_mem_timer

Memory-mapped timer peripheral that acts as a responder on the CPU core's data-memory port (address, write data, write enable, read data). It decodes a 32-byte window at `BASE_ADDR`, returns register contents combinationally in the same cycle so the single-cycle core can consume them, and applies writes on the clock edge. It runs a prescaled 32-bit up-counter with compare-match, a sticky match flag and an interrupt line. It sits beside data RAM behind the core's data bus address decode.

## Interface
- `BASE_ADDR`, default 32'h0000_1000, word-aligned base of the 32-byte register window.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `dataMemRAddr`  in  32  byte address from the core.
- `dataMemWData`  in  32  write data from the core.
- `dataMem_wr_en`  in  1  write strobe; a write occurs when high and `hit` is high.
- `dataMemRData`  out  32  read data; combinational from `dataMemRAddr`.
- `hit`  out  1  high when `dataMemRAddr[31:5] == BASE_ADDR[31:5]`; used by the upstream read-data mux.
- `irq`  out  1  `STATUS.MATCH & CTRL.IRQ_EN`, driven from registers.

## Operation
- The register is selected by `dataMemRAddr[4:2]`. `dataMemRAddr[1:0]` is ignored. Writes are full-word only.
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bit3 ONESHOT (see Configuration). Other bits read 0.
  - 0x04 PSC: bits[15:0] prescale value. Upper bits read 0.
  - 0x08 CNT: 32-bit counter, read/write.
  - 0x0C CMP: 32-bit compare value, read/write.
  - 0x10 STATUS: bit0 MATCH, sticky. Writing 1 clears it; writing 0 has no effect.
  - 0x14–0x1C: read 0, writes ignored.
- When `hit` is 0, `dataMemRData` = 0.
- Prescaler:
  - Internal 16-bit `pscCnt` advances only while EN = 1.
  - `tick` = EN & (`pscCnt == PSC`). On `tick`, `pscCnt` returns to 0; otherwise it increments.
  - With EN = 0, `pscCnt` holds its value.
- Counter:
  - On `tick`, CNT increments modulo 2^32, so 0xFFFF_FFFF wraps to 0 with no flag.
  - A match event occurs when `tick` is high and CNT == CMP (the value before the update).
  - On a match event: MATCH is set. If AUTO_RELOAD = 1, CNT is set to 0; otherwise CNT increments normally.
- Simultaneous events:
  - A software write to CNT overrides the tick update in the same cycle.
  - A software write to PSC also resets `pscCnt` to 0.
  - A match-set of MATCH in the same cycle as a W1C write leaves MATCH = 1 (set wins).
  - A write to CMP in the match cycle: the comparison uses the old CMP.
- Reset (active-low, synchronous):
  - CTRL, PSC, CNT, CMP, STATUS and `pscCnt` all go to 0. `irq` = 0.
  - `dataMemRData` reflects the zeroed registers.
  - Reset asserted mid-count discards all progress. The reset cycle takes priority over any write in that cycle.

## Timing
- Read latency is 0 cycles: `dataMemRData` is valid in the same cycle `dataMemRAddr` is presented.
- Write latency is 1 edge: a read of the same register in the next cycle returns the new value.
- With PSC = N and EN = 1, CNT increments once every N+1 cycles. The first increment occurs N+1 edges after the edge that set EN, given `pscCnt` = 0.
- `irq` rises in the cycle after the match-event edge, i.e. combinationally from the registered MATCH. It falls in the cycle after the W1C edge.
- No wait states and no handshake: every access completes in one cycle.

## Configuration
- Macro: `TIMER_ONESHOT_EN`.
- Defined:
  - CTRL bit3 ONESHOT is implemented.
  - On a match event with ONESHOT = 1, EN is cleared in the same edge. The CNT update (reload or increment) still applies.
  - A software write to CTRL in that same cycle wins over the automatic EN clear.
- Undefined: CTRL bit3 reads 0, writes to it are ignored, and EN is never cleared by hardware.

## Test plan
- Reset and decode:
  - Hold `reset` = 0 for 2 cycles, then read all 8 offsets → all return 0, `irq` = 0.
  - Read address `BASE_ADDR` + 0x20 → `hit` = 0, data 0.
- Prescaled count:
  - PSC = 3, CNT = 0, CTRL = 0x1, run 12 cycles → CNT = 3. Clear EN → CNT and `pscCnt` hold for 10 cycles.
- Match with auto-reload and irq:
  - PSC = 0, CMP = 5, CTRL = 0x7 → CNT sequence 0..5,0,1. MATCH set after the 0→… cycle where CNT = 5. `irq` = 1 one cycle later.
  - Write STATUS = 1 → `irq` = 0 next cycle.
- Wrap and collisions:
  - CNT = 0xFFFF_FFFF, PSC = 0, EN = 1 → next CNT = 0, MATCH stays 0 (CMP = 0x10).
  - Write CNT = 0x40 in a tick cycle → CNT = 0x40.
  - Write STATUS = 1 in the match cycle → MATCH = 1.
- Reset mid-operation: counting with CNT = 0x20 and MATCH = 1, pull `reset` low one cycle together with a CNT write → all registers 0, `irq` = 0.
- `TIMER_ONESHOT_EN`:
  - Defined: CMP = 2, CTRL = 0xB, PSC = 0 → after the match CTRL reads 0xA and CNT = 0 and holds.
  - Undefined: CTRL bit3 reads 0 and counting continues.
